// File: rtl/detect_seq_ctrl.sv
// Word-serialising controller wrapped around an overlapping Moore detector for 10110.
// Accepts a word, shifts it MSB first through the detector, reports per-word and running match counts.
module detect_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             keep,
    input  logic             clr_total,
    output logic             in_ready,
    output logic             busy,
    output logic             ser_bit,
    output logic             det_w,
    output logic             done,
    output logic [3:0]       match_cnt,
    output logic [7:0]       total_cnt
);

    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned MCNT_W = 4;
    localparam int unsigned TOT_W  = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [2:0] {D_A, D_B, D_C, D_D, D_E, D_F} det_t;

    state_t              r_state, w_state_nxt;
    det_t                r_det, w_det_nxt;
    logic [WIDTH-1:0]    r_sh, w_sh_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [MCNT_W-1:0]   r_mcnt, w_mcnt_nxt;
    logic [TOT_W-1:0]    r_tot, w_tot_nxt;
    logic                w_hit;
    logic                r_in_ready, r_busy, r_done, r_det_w;

    // One detector step for pattern 10110 with overlap.
    function automatic det_t det_step(input det_t s, input logic b);
        det_t n;
        case (s)
            D_A:     n = b ? D_B : D_A;
            D_B:     n = b ? D_B : D_C;
            D_C:     n = b ? D_D : D_A;
            D_D:     n = b ? D_E : D_C;
            D_E:     n = b ? D_B : D_F;
            D_F:     n = b ? D_D : D_A;
            default: n = D_A;
        endcase
        return n;
    endfunction

    // Next-state, datapath and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_det_nxt   = r_det;
        w_sh_nxt    = r_sh;
        w_idx_nxt   = r_idx;
        w_mcnt_nxt  = r_mcnt;
        w_hit       = 1'b0;
        w_tot_nxt   = r_tot;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_sh_nxt    = in_data;
                    w_idx_nxt   = '0;
                    w_mcnt_nxt  = '0;
                    w_det_nxt   = keep ? r_det : D_A;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_det_nxt = det_step(r_det, r_sh[WIDTH-1]);
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
                w_idx_nxt = r_idx + IDX_W'(1);
                if (w_det_nxt == D_F) begin
                    w_hit      = 1'b1;
                    w_mcnt_nxt = r_mcnt + MCNT_W'(1);
                end
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Clear beats a same-edge increment; the running total never wraps.
        if (clr_total) begin
            w_tot_nxt = '0;
        end else if (w_hit && (r_tot != '1)) begin
            w_tot_nxt = r_tot + TOT_W'(1);
        end
    end

    // State and registered outputs, decoded one cycle ahead from next-state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_det      <= D_A;
            r_sh       <= '0;
            r_idx      <= '0;
            r_mcnt     <= '0;
            r_tot      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_det_w    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_det      <= w_det_nxt;
            r_sh       <= w_sh_nxt;
            r_idx      <= w_idx_nxt;
            r_mcnt     <= w_mcnt_nxt;
            r_tot      <= w_tot_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_det_w    <= (w_det_nxt == D_F);
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign det_w     = r_det_w;
    assign ser_bit   = r_sh[WIDTH-1];
    assign match_cnt = r_mcnt;
    assign total_cnt = r_tot;

endmodule
